// File: rtl/clkswitch_sequencer_if.sv
// Signal bundle between the clock-switch sequencer and its environment
// (CPU request side plus the clock switch select/status lines).
interface clkswitch_sequencer_if;
    logic       hs_req;
    logic       ls_force;
    logic [1:0] div_sel_in;
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       busy;
    logic       in_hs;
    logic       timeout_err;

    modport master (
        input  hs_req,
        input  ls_force,
        input  div_sel_in,
        input  hsclk_selected,
        input  lsclk_selected,
        output hsclk_sel,
        output cpuclk_div_sel,
        output busy,
        output in_hs,
        output timeout_err
    );

    modport slave (
        output hs_req,
        output ls_force,
        output div_sel_in,
        output hsclk_selected,
        output lsclk_selected,
        input  hsclk_sel,
        input  cpuclk_div_sel,
        input  busy,
        input  in_hs,
        input  timeout_err
    );
endinterface

// File: rtl/clkswitch_sequencer.sv
// Control-side sequencer for the glitch-free CPU clock switch: drives select/divider,
// waits for the switch's synchronised status, enforces dwell and handshake timeout.
module clkswitch_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DWELL       = 8,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 8
) (
    input logic                   clk_in,
    input logic                   rst,
    clkswitch_sequencer_if.master sw
);
    typedef enum logic [1:0] {StLsStable, StGoHs, StHsStable, StGoLs} state_e;

    localparam logic [CNT_W-1:0] DwellCnt   = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   cnt_restart;
    logic [SYNC_STAGES-1:0] hs_sync_q, ls_sync_q;
    logic                   hs_s, ls_s;
    logic                   hsclk_sel_q, hsclk_sel_d;
    logic [1:0]             div_q, div_d;
    logic                   busy_q, busy_d;
    logic                   in_hs_q, in_hs_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   timeout_hit;

    // Reset values mirror the switch coming out of reset on the slow clock.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            hs_sync_q <= '0;
            ls_sync_q <= '1;
        end else begin
            hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], sw.hsclk_selected};
            ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], sw.lsclk_selected};
        end
    end

    assign hs_s = hs_sync_q[SYNC_STAGES-1];
    assign ls_s = ls_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= StLsStable;
            cnt_q         <= '0;
            hsclk_sel_q   <= 1'b0;
            div_q         <= 2'b00;
            busy_q        <= 1'b0;
            in_hs_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hsclk_sel_q   <= hsclk_sel_d;
            div_q         <= div_d;
            busy_q        <= busy_d;
            in_hs_q       <= in_hs_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_restart = 1'b0;
        case (state_q)
            StLsStable: begin
                if (cnt_q >= DwellCnt && sw.hs_req && !sw.ls_force) state_d = StGoHs;
            end
            StGoHs: begin
                // Request changes here are deliberately ignored until the ack arrives.
                if (hs_s && !ls_s)             state_d = StHsStable;
                else if (cnt_q == TimeoutCnt)  state_d = StGoLs;
            end
            StHsStable: begin
                if (sw.ls_force || (!sw.hs_req && cnt_q >= DwellCnt)) state_d = StGoLs;
            end
            StGoLs: begin
                if (ls_s && !hs_s)             state_d = StLsStable;
                else if (cnt_q == TimeoutCnt)  cnt_restart = 1'b1;
            end
            default: state_d = StLsStable;
        endcase

        if (state_d != state_q || cnt_restart) cnt_d = '0;
        else if (cnt_q == CntMax)              cnt_d = cnt_q;
        else                                   cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        hsclk_sel_d   = hsclk_sel_q;
        div_d         = div_q;
        timeout_hit   = cnt_restart || (state_q == StGoHs && state_d == StGoLs);
        timeout_err_d = timeout_err_q | timeout_hit;
        busy_d        = (state_d == StGoHs) || (state_d == StGoLs);
        in_hs_d       = (state_d == StHsStable);
        if (state_q == StLsStable && state_d == StGoHs) begin
            hsclk_sel_d = 1'b1;
            div_d       = sw.div_sel_in;
        end
        if (state_q != StGoLs && state_d == StGoLs) hsclk_sel_d = 1'b0;
    end

    assign sw.hsclk_sel      = hsclk_sel_q;
    assign sw.cpuclk_div_sel = div_q;
    assign sw.busy           = busy_q;
    assign sw.in_hs          = in_hs_q;
    assign sw.timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_clkswitch_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes (cycle + value), a negedge
// monitor pops one entry on every change of the output vector and compares.
module tb_clkswitch_sequencer;
    typedef struct {
        string       name;
        int          cyc;
        logic [5:0]  vec;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    bit   mon_en = 1'b0;
    bit   first = 1'b1;
    logic [5:0] prev;
    logic [5:0] vec;
    logic [4:0] dly = '0;
    logic ack_hs_en = 1'b1;

    clkswitch_sequencer_if sw_if();

    clkswitch_sequencer dut (
        .clk_in (clk_in),
        .rst    (rst),
        .sw     (sw_if)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Switch model: status follows the select 5 cycles later; hs ack can be suppressed.
    always @(posedge clk_in) dly <= rst ? 5'b0 : {dly[3:0], sw_if.hsclk_sel};
    assign sw_if.hsclk_selected = dly[4] & ack_hs_en;
    assign sw_if.lsclk_selected = ~dly[4];

    function automatic logic [5:0] v(bit to, bit b, bit ih, bit hs, logic [1:0] d);
        return {to, b, ih, hs, d};
    endfunction

    function automatic void push(string name, int c, logic [5:0] x);
        exp_t t;
        t.name = name;
        t.cyc  = c;
        t.vec  = x;
        exp_q.push_back(t);
    endfunction

    task automatic tick_to(int t);
        while (cyc < t) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // vec = {timeout_err, busy, in_hs, hsclk_sel, cpuclk_div_sel}
    always @(negedge clk_in) begin
        if (mon_en) begin
            vec = {sw_if.timeout_err, sw_if.busy, sw_if.in_hs, sw_if.hsclk_sel,
                   sw_if.cpuclk_div_sel};
            if (first || vec !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cycle %0d got %b, required no change",
                             cyc, vec);
                end else begin
                    e = exp_q.pop_front();
                    if (e.vec !== vec || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 e.name, vec, cyc, e.vec, e.cyc);
                    end
                end
            end
            prev  = vec;
            first = 1'b0;
        end
    end

    initial begin
        rst                = 1'b1;
        sw_if.hs_req       = 1'b0;
        sw_if.ls_force     = 1'b0;
        sw_if.div_sel_in   = 2'd0;
        tick_to(3);
        rst    = 1'b0;
        mon_en = 1'b1;
        push("reset", 3, v(0, 0, 0, 0, 2'd0));

        // Idle, then first LS->HS with div 1
        tick_to(23);
        sw_if.hs_req     = 1'b1;
        sw_if.div_sel_in = 2'd1;
        push("go_hs", 24, v(0, 1, 0, 1, 2'd1));
        push("hs_stable", 32, v(0, 0, 1, 1, 2'd1));

        // ls_force pulse at cnt=2 in HS_STABLE with hs_req high
        tick_to(34);
        sw_if.ls_force = 1'b1;
        push("force_go_ls", 35, v(0, 1, 0, 0, 2'd1));
        push("force_ls_stable", 43, v(0, 0, 0, 0, 2'd1));
        tick_to(35);
        sw_if.ls_force = 1'b0;
        sw_if.hs_req   = 1'b0;

        // Dwell: 3-cycle pulse ignored, held request honoured once cnt reaches 8
        tick_to(43);
        sw_if.hs_req = 1'b1;
        tick_to(46);
        sw_if.hs_req = 1'b0;
        tick_to(47);
        sw_if.hs_req = 1'b1;
        push("dwell_go_hs", 52, v(0, 1, 0, 1, 2'd1));
        push("dwell_hs_stable", 60, v(0, 0, 1, 1, 2'd1));

        // Divider changes while in HS are ignored
        tick_to(61);
        sw_if.div_sel_in = 2'd2;
        tick_to(62);
        sw_if.div_sel_in = 2'd3;
        tick_to(63);
        sw_if.div_sel_in = 2'd2;
        tick_to(64);
        sw_if.hs_req = 1'b0;
        push("dwell_go_ls", 69, v(0, 1, 0, 0, 2'd1));
        push("dwell_ls_stable", 77, v(0, 0, 0, 0, 2'd1));

        // Next LS->HS latches the new divider
        tick_to(80);
        sw_if.hs_req = 1'b1;
        push("div_go_hs", 86, v(0, 1, 0, 1, 2'd2));
        push("div_hs_stable", 94, v(0, 0, 1, 1, 2'd2));
        tick_to(94);
        sw_if.hs_req = 1'b0;
        push("div_go_ls", 103, v(0, 1, 0, 0, 2'd2));
        push("div_ls_stable", 111, v(0, 0, 0, 0, 2'd2));

        // Switch never acks hs: timeout after 255 cycles, then recover to LS
        tick_to(111);
        ack_hs_en        = 1'b0;
        sw_if.hs_req     = 1'b1;
        sw_if.div_sel_in = 2'd3;
        push("to_go_hs", 120, v(0, 1, 0, 1, 2'd3));
        push("timeout", 376, v(1, 1, 0, 0, 2'd3));
        push("to_ls_stable", 384, v(1, 0, 0, 0, 2'd3));
        tick_to(130);
        sw_if.hs_req = 1'b0;

        // Reset while in GO_HS aborts the handshake and clears timeout_err
        tick_to(384);
        ack_hs_en        = 1'b1;
        sw_if.hs_req     = 1'b1;
        sw_if.div_sel_in = 2'd0;
        push("rst_go_hs", 393, v(1, 1, 0, 1, 2'd0));
        push("rst_abort", 396, v(0, 0, 0, 0, 2'd0));
        tick_to(395);
        rst = 1'b1;
        tick_to(396);
        rst          = 1'b0;
        sw_if.hs_req = 1'b0;

        tick_to(420);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: %0d left, required 0 (next %s at cycle %0d)",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
